// File: rtl/mips_cpu_muldiv.sv
// ---------------------------------------------------------------------------
// mips_cpu_muldiv : iterative MIPS multiply/divide unit owning HI/LO
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_FIX     = 2'd2;
  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_borrow;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // op[0] set means unsigned; signed ops work on magnitudes and fix signs at the end
  assign a_mag = (!op[0] && a[WIDTH-1]) ? -a : a;
  assign b_mag = (!op[0] && b[WIDTH-1]) ? -b : b;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // Dividend bits shift out of the top of acc_q[WIDTH-1:0] while quotient bits enter at the bottom
  assign div_shift  = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_diff   = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_borrow = div_diff[WIDTH+1];

  assign prod_fix = neg_lo_q  ? -acc_q : acc_q;
  assign quot_fix = neg_lo_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    a_orig_d   = a_orig_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          cnt_d      = 6'd0;
          is_div_d   = op[1];
          neg_lo_d   = !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = !op[0] && a[WIDTH-1];
          div_zero_d = (b == {WIDTH{1'b0}});
          a_orig_d   = a;
          opnd_d     = op[1] ? b_mag : a_mag;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          rem_d      = {(WIDTH+1){1'b0}};
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          rem_d              = div_borrow ? div_shift : div_diff[WIDTH:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], ~div_borrow};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = a_orig_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_orig_q   <= {WIDTH{1'b0}};
      opnd_q     <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      rem_q      <= {(WIDTH+1){1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      a_orig_q   <= a_orig_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_muldiv : directed self-checking bench for mips_cpu_muldiv
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_cpu_muldiv;

  localparam logic [1:0] c_MULT  = 2'b00;
  localparam logic [1:0] c_MULTU = 2'b01;
  localparam logic [1:0] c_DIV   = 2'b10;
  localparam logic [1:0] c_DIVU  = 2'b11;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation and follows it to completion. inject_edge > 0 pulses a
  // conflicting start + mthi so that it is sampled on that edge after the start edge.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inject_edge);
    logic [31:0] h0, l0;
    int          cyc;
    bit          quiet;
    @(posedge clk); #1;
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    cyc   = 0;
    quiet = 1'b1;
    while (busy && cyc < 40) begin
      if (hi !== h0 || lo !== l0 || done !== 1'b0) quiet = 1'b0;
      if (inject_edge > 0 && cyc == inject_edge - 1) begin
        start = 1'b1; op = c_MULTU; a = 32'd3; b = 32'd3;
        mthi = 1'b1; wdata = 32'h0000DEAD;
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; mthi = 1'b0;
    end
    check_val({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
    check_val({tag, "_quiet_run"}, {63'd0, quiet}, 64'd1);
    check_val({tag, "_done"}, {63'd0, done}, 64'd1);
    check_val({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check_val({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    @(posedge clk); #1;
    check_val({tag, "_done_drop"}, {63'd0, done}, 64'd0);
  endtask

  task automatic mt_write(input string tag, input logic wh, input logic wl,
                          input logic [31:0] d, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
    @(posedge clk); #1;
    mthi = wh; mtlo = wl; wdata = d;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check_val({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check_val({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check_val({tag, "_nodone"}, {63'd0, done}, 64'd0);
    check_val({tag, "_nobusy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_hi", {32'd0, hi}, 64'd0);
    check_val("rst_lo", {32'd0, lo}, 64'd0);

    run_op("multu_max",  c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("mult_neg3x7", c_MULT, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_op("mult_minmin", c_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    run_op("div_neg7_2",  c_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div_7_neg2",  c_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    run_op("divu_100_7",  c_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       0);
    run_op("div_min_m1",  c_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_op("divu_by0",    c_DIVU, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 0);
    run_op("div_by0",     c_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    run_op("busy_confl",  c_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       10);

    mt_write("mt_both", 1'b1, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    mt_write("mt_hi",   1'b1, 1'b0, 32'h11111111, 32'h11111111, 32'hA5A5A5A5);

    // Asynchronous reset halfway between edges 15 and 16 of a running multiply
    @(posedge clk); #1;
    start = 1'b1; op = c_MULTU; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    check_val("arst_busy", {63'd0, busy}, 64'd0);
    check_val("arst_done", {63'd0, done}, 64'd0);
    check_val("arst_hi", {32'd0, hi}, 64'd0);
    check_val("arst_lo", {32'd0, lo}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("arst_idle", {63'd0, busy}, 64'd0);

    run_op("multu_2x3", c_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
